rns_compare_seq: RTL and testbench

- Sequential, handshaked comparator for two numbers X, Y in a 3-modulus residue number system (RNS) with parametrised pairwise-coprime moduli M1, M2, M3.
- Successor to the fixed 9/8/7 combinational comparator. Adds generic moduli, a runtime signed/unsigned mode, and out-of-range residue detection.
- Uses iterative mixed-radix conversion (MRC) over a small FSM, with valid/ready on both sides.
- Sits between RNS arithmetic units and control logic needing magnitude decisions.

---
 rtl/rns_compare_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_rns_compare_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rns_compare_seq.sv
// rns_compare_seq: handshaked magnitude comparator for 3-modulus RNS operands.
// Residues are converted to mixed-radix digits over two cycles, then the
// reconstructed values are compared (unsigned, or signed with the upper half
// of the range taken as negative). Out-of-range residues force err.
module rns_compare_seq #(
    parameter  int unsigned M1 = 9,
    parameter  int unsigned M2 = 8,
    parameter  int unsigned M3 = 7,
    localparam int unsigned W1 = $clog2(M1),
    localparam int unsigned W2 = $clog2(M2),
    localparam int unsigned W3 = $clog2(M3)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode_signed,
    input  logic [W1-1:0] x1,
    input  logic [W2-1:0] x2,
    input  logic [W3-1:0] x3,
    input  logic [W1-1:0] y1,
    input  logic [W2-1:0] y2,
    input  logic [W3-1:0] y3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          le,
    output logic          eq,
    output logic          gr,
    output logic          err
);

    // Modular inverse of a mod m by search; elaboration-time only.
    function automatic int unsigned f_inv(input int unsigned a, input int unsigned m);
        int unsigned r;
        r = 0;
        for (int unsigned i = 1; i < m; i++) begin
            if (r == 0 && (((a % m) * i) % m) == 1) r = i;
        end
        return r;
    endfunction

    localparam int unsigned M     = M1 * M2 * M3;
    localparam int unsigned WM    = $clog2(M);
    localparam int unsigned HALF  = (M + 1) / 2;
    localparam int unsigned INV12 = f_inv(M1, M2);
    localparam int unsigned INV13 = f_inv(M1, M3);
    localparam int unsigned INV23 = f_inv(M2, M3);
    // Common width able to hold any residue and any modulus value.
    localparam int unsigned WMAX  = (W1 > W2) ? ((W1 > W3) ? W1 : W3) : ((W2 > W3) ? W2 : W3);
    localparam int unsigned WA    = WMAX + 1;
    localparam int unsigned WP2   = 2 * W2 + 1;
    localparam int unsigned WP3   = 2 * W3 + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MR2,
        S_MR3,
        S_CMP,
        S_DONE
    } state_t;

    // ((r - a) mod M2) * INV12 mod M2; a is reduced first since it may exceed M2.
    function automatic logic [W2-1:0] f_mr2(input logic [W2-1:0] r, input logic [WA-1:0] a);
        logic [WA-1:0]  a_red;
        logic [WP2-1:0] d;
        a_red = a % WA'(M2);
        d     = (WP2'(r) + WP2'(M2) - WP2'(a_red)) % WP2'(M2);
        return W2'((d * WP2'(INV12)) % WP2'(M2));
    endfunction

    // ((r - a) mod M3) * inv mod M3.
    function automatic logic [W3-1:0] f_mr3(input logic [W3-1:0] r, input logic [WA-1:0] a,
                                            input logic [W3-1:0] inv);
        logic [WA-1:0]  a_red;
        logic [WP3-1:0] d;
        a_red = a % WA'(M3);
        d     = (WP3'(r) + WP3'(M3) - WP3'(a_red)) % WP3'(M3);
        return W3'((d * WP3'(inv)) % WP3'(M3));
    endfunction

    state_t        r_state;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_le;
    logic          r_eq;
    logic          r_gr;
    logic          r_err;
    logic          r_bad;
    logic          r_mode;
    logic [W1-1:0] r_x1;
    logic [W2-1:0] r_x2;
    logic [W3-1:0] r_x3;
    logic [W1-1:0] r_y1;
    logic [W2-1:0] r_y2;
    logic [W3-1:0] r_y3;
    logic [W2-1:0] r_a2x;
    logic [W2-1:0] r_a2y;
    logic [W3-1:0] r_t3x;
    logic [W3-1:0] r_t3y;
    logic [W3-1:0] r_a3x;
    logic [W3-1:0] r_a3y;

    logic [W2-1:0] w_a2x;
    logic [W2-1:0] w_a2y;
    logic [W3-1:0] w_t3x;
    logic [W3-1:0] w_t3y;
    logic [W3-1:0] w_a3x;
    logic [W3-1:0] w_a3y;
    logic [WM-1:0] w_vx;
    logic [WM-1:0] w_vy;
    logic          w_negx;
    logic          w_negy;
    logic          w_lt;
    logic          w_eq;
    logic          w_range_err;

    // Mixed-radix digit datapath, X and Y in parallel.
    assign w_a2x = f_mr2(r_x2, WA'(r_x1));
    assign w_a2y = f_mr2(r_y2, WA'(r_y1));
    assign w_t3x = f_mr3(r_x3, WA'(r_x1), W3'(INV13));
    assign w_t3y = f_mr3(r_y3, WA'(r_y1), W3'(INV13));
    assign w_a3x = f_mr3(r_t3x, WA'(r_a2x), W3'(INV23));
    assign w_a3y = f_mr3(r_t3y, WA'(r_a2y), W3'(INV23));

    // Positional value from the digits: a1 + a2*M1 + a3*M1*M2.
    assign w_vx = WM'(r_x1) + WM'(r_a2x) * WM'(M1) + WM'(r_a3x) * WM'(M1 * M2);
    assign w_vy = WM'(r_y1) + WM'(r_a2y) * WM'(M1) + WM'(r_a3y) * WM'(M1 * M2);

    // In signed mode differing signs decide directly; same sign keeps the V order.
    assign w_negx = (w_vx >= WM'(HALF));
    assign w_negy = (w_vy >= WM'(HALF));
    assign w_lt   = (r_mode && (w_negx != w_negy)) ? w_negx : (w_vx < w_vy);
    assign w_eq   = (w_vx == w_vy);

    assign w_range_err = (WA'(x1) >= WA'(M1)) || (WA'(x2) >= WA'(M2)) || (WA'(x3) >= WA'(M3)) ||
                         (WA'(y1) >= WA'(M1)) || (WA'(y2) >= WA'(M2)) || (WA'(y3) >= WA'(M3));

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_le        <= 1'b0;
            r_eq        <= 1'b0;
            r_gr        <= 1'b0;
            r_err       <= 1'b0;
            r_bad       <= 1'b0;
            r_mode      <= 1'b0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_x3        <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_y3        <= '0;
            r_a2x       <= '0;
            r_a2y       <= '0;
            r_t3x       <= '0;
            r_t3y       <= '0;
            r_a3x       <= '0;
            r_a3y       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_x1       <= x1;
                        r_x2       <= x2;
                        r_x3       <= x3;
                        r_y1       <= y1;
                        r_y2       <= y2;
                        r_y3       <= y3;
                        r_mode     <= mode_signed;
                        r_bad      <= w_range_err;
                        r_in_ready <= 1'b0;
                        r_state    <= S_MR2;
                    end
                end
                S_MR2: begin
                    r_a2x   <= w_a2x;
                    r_a2y   <= w_a2y;
                    r_t3x   <= w_t3x;
                    r_t3y   <= w_t3y;
                    r_state <= S_MR3;
                end
                S_MR3: begin
                    r_a3x   <= w_a3x;
                    r_a3y   <= w_a3y;
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    r_out_valid <= 1'b1;
                    r_err       <= r_bad;
                    r_le        <= !r_bad && w_lt;
                    r_eq        <= !r_bad && w_eq;
                    r_gr        <= !r_bad && !w_lt && !w_eq;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_le        <= 1'b0;
                        r_eq        <= 1'b0;
                        r_gr        <= 1'b0;
                        r_err       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign le        = r_le;
    assign eq        = r_eq;
    assign gr        = r_gr;
    assign err       = r_err;

endmodule

// File: tb/tb_rns_compare_seq.sv
// Bench for rns_compare_seq: default moduli (9/8/7) and an alternate set (5/3/7).
module tb_rns_compare_seq;

    logic clk;
    logic rst;

    // Default-moduli instance signals
    logic       d0_in_valid, d0_in_ready, d0_mode, d0_out_valid, d0_out_ready;
    logic       d0_le, d0_eq, d0_gr, d0_err;
    logic [3:0] d0_x1, d0_y1;
    logic [2:0] d0_x2, d0_x3, d0_y2, d0_y3;

    // Alternate-moduli instance signals (M1=5, M2=3, M3=7)
    logic       d1_in_valid, d1_in_ready, d1_mode, d1_out_valid, d1_out_ready;
    logic       d1_le, d1_eq, d1_gr, d1_err;
    logic [2:0] d1_x1, d1_y1, d1_x3, d1_y3;
    logic [1:0] d1_x2, d1_y2;

    int n_checks;
    int n_errors;

    rns_compare_seq u_dut0 (
        .clk(clk), .rst(rst), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .mode_signed(d0_mode), .x1(d0_x1), .x2(d0_x2), .x3(d0_x3),
        .y1(d0_y1), .y2(d0_y2), .y3(d0_y3), .out_valid(d0_out_valid),
        .out_ready(d0_out_ready), .le(d0_le), .eq(d0_eq), .gr(d0_gr), .err(d0_err)
    );

    rns_compare_seq #(.M1(5), .M2(3), .M3(7)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .mode_signed(d1_mode), .x1(d1_x1), .x2(d1_x2), .x3(d1_x3),
        .y1(d1_y1), .y2(d1_y2), .y3(d1_y3), .out_valid(d1_out_valid),
        .out_ready(d1_out_ready), .le(d1_le), .eq(d1_eq), .gr(d1_gr), .err(d1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1);
    end

    // Result codes: le=1, eq=2, gr=4, err=8
    typedef struct {
        int sel;
        int x;
        int y;
        bit sgn;
        int exp;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s act=%0d req=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mod_of(input int sel, input int k);
        if (sel == 0) return (k == 1) ? 9 : (k == 2) ? 8 : 7;
        return (k == 1) ? 5 : (k == 2) ? 3 : 7;
    endfunction

    // Reference: compare integers directly, mapping the upper half to negative in signed mode.
    function automatic int model(input int sel, input int x, input int y, input bit sgn);
        int m, sx, sy;
        m  = mod_of(sel, 1) * mod_of(sel, 2) * mod_of(sel, 3);
        sx = x;
        sy = y;
        if (sgn) begin
            if (x >= (m + 1) / 2) sx = x - m;
            if (y >= (m + 1) / 2) sy = y - m;
        end
        if (sx < sy) return 1;
        if (sx == sy) return 2;
        return 4;
    endfunction

    function automatic int code_of(input int sel);
        if (sel == 0) return 8 * int'(d0_err) + 4 * int'(d0_gr) + 2 * int'(d0_eq) + int'(d0_le);
        return 8 * int'(d1_err) + 4 * int'(d1_gr) + 2 * int'(d1_eq) + int'(d1_le);
    endfunction

    function automatic int ready_of(input int sel);
        return (sel == 0) ? int'(d0_in_ready) : int'(d1_in_ready);
    endfunction

    function automatic int valid_of(input int sel);
        return (sel == 0) ? int'(d0_out_valid) : int'(d1_out_valid);
    endfunction

    task automatic drive(input int sel, input int a1, input int a2, input int a3,
                         input int b1, input int b2, input int b3, input bit m, input bit v);
        if (sel == 0) begin
            d0_x1 = 4'(a1); d0_x2 = 3'(a2); d0_x3 = 3'(a3);
            d0_y1 = 4'(b1); d0_y2 = 3'(b2); d0_y3 = 3'(b3);
            d0_mode = m; d0_in_valid = v;
        end else begin
            d1_x1 = 3'(a1); d1_x2 = 2'(a2); d1_x3 = 3'(a3);
            d1_y1 = 3'(b1); d1_y2 = 2'(b2); d1_y3 = 3'(b3);
            d1_mode = m; d1_in_valid = v;
        end
    endtask

    // Present operands and return #1 after the accepting edge; inputs are then scrambled.
    task automatic start_op(input int sel, input int a1, input int a2, input int a3,
                            input int b1, input int b2, input int b3, input bit m);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        drive(sel, a1, a2, a3, b1, b2, b3, m, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (ready_of(sel) != 0) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        drive(sel, int'($urandom), int'($urandom), int'($urandom),
              int'($urandom), int'($urandom), int'($urandom), 1'($urandom), 1'b0);
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    // Count edges after accept until out_valid; 0 means it never came.
    task automatic wait_result(input int sel, output int code, output int lat);
        lat  = 0;
        code = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (valid_of(sel) != 0) begin
                lat  = i;
                code = code_of(sel);
                break;
            end
        end
    endtask

    task automatic op_int(input int sel, input int x, input int y, input bit m,
                          input int exp, input string nm);
        int code, lat;
        start_op(sel, x % mod_of(sel, 1), x % mod_of(sel, 2), x % mod_of(sel, 3),
                 y % mod_of(sel, 1), y % mod_of(sel, 2), y % mod_of(sel, 3), m);
        wait_result(sel, code, lat);
        check(nm, code, exp);
        check("latency", lat, 3);
    endtask

    vec_t vt[11];

    initial begin
        int code, lat, seen;
        n_checks = 0;
        n_errors = 0;

        vt[0]  = '{0, 503,   0, 1'b0, 4};
        vt[1]  = '{0, 503,   0, 1'b1, 1};
        vt[2]  = '{0, 251, 252, 1'b0, 1};
        vt[3]  = '{0, 251, 252, 1'b1, 4};
        vt[4]  = '{0,   0,   0, 1'b1, 2};
        vt[5]  = '{0, 252, 503, 1'b1, 1};
        vt[6]  = '{1, 104,  52, 1'b0, 4};
        vt[7]  = '{1, 104,  52, 1'b1, 1};
        vt[8]  = '{1,  52,  53, 1'b1, 4};
        vt[9]  = '{1,  53, 104, 1'b1, 1};
        vt[10] = '{1, 104, 104, 1'b0, 2};

        rst = 1'b1;
        d0_out_ready = 1'b1;
        d1_out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        drive(1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready0", ready_of(0), 1);
        check("reset_valid0", valid_of(0), 0);
        check("reset_code0", code_of(0), 0);
        check("reset_ready1", ready_of(1), 1);
        check("reset_valid1", valid_of(1), 0);
        check("reset_code1", code_of(1), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        foreach (vt[i]) op_int(vt[i].sel, vt[i].x, vt[i].y, vt[i].sgn, vt[i].exp, "table");

        // Full unsigned sweep at default moduli
        for (int i = 0; i < 504; i++) op_int(0, i, 503 - i, 1'b0, (i > 503 - i) ? 4 : 1, "sweep_xy");
        for (int i = 0; i < 504; i++) op_int(0, i, i, 1'b0, 2, "sweep_eq");
        for (int i = 0; i < 504; i++) op_int(0, 503 - i, i, 1'b0, (503 - i > i) ? 4 : 1, "sweep_swap");

        // Randomised operands against the integer model
        for (int n = 0; n < 300; n++) begin
            int sel, m, x, y;
            bit sg;
            sel = int'($urandom_range(0, 1));
            m   = mod_of(sel, 1) * mod_of(sel, 2) * mod_of(sel, 3);
            x   = int'($urandom_range(0, m - 1));
            y   = ($urandom_range(0, 7) == 0) ? x : int'($urandom_range(0, m - 1));
            sg  = 1'($urandom);
            op_int(sel, x, y, sg, model(sel, x, y, sg), "random");
        end

        // Range error, then a clean operation
        start_op(0, 9, 0, 0, 0, 0, 0, 1'b0);
        wait_result(0, code, lat);
        check("range_err", code, 8);
        check("range_err_lat", lat, 3);
        op_int(0, 1, 0, 1'b0, 4, "after_err");
        start_op(1, 0, 3, 0, 0, 0, 0, 1'b0);
        wait_result(1, code, lat);
        check("range_err_alt", code, 8);
        op_int(1, 2, 0, 1'b0, 4, "after_err_alt");

        // Backpressure: hold DONE for 6 cycles while new operands are offered
        start_op(0, 5, 5, 5, 3, 3, 3, 1'b0);
        d0_out_ready = 1'b0;
        wait_result(0, code, lat);
        check("bp_first", code, 4);
        check("bp_lat", lat, 3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 7, 7, 0, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            check("bp_hold_valid", valid_of(0), 1);
            check("bp_hold_code", code_of(0), 4);
            check("bp_hold_ready", ready_of(0), 0);
        end
        @(negedge clk);
        d0_out_ready = 1'b1;
        @(posedge clk);
        #1;
        d0_in_valid = 1'b0;
        check("bp_release_ready", ready_of(0), 1);
        check("bp_release_valid", valid_of(0), 0);
        check("bp_release_code", code_of(0), 0);
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen += valid_of(0);
        end
        check("bp_no_ghost", seen, 0);

        // Reset while in MR3 discards the operation
        start_op(0, 1, 2, 3, 4, 5, 6, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ready", ready_of(0), 1);
        check("rst_mid_valid", valid_of(0), 0);
        check("rst_mid_code", code_of(0), 0);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen += valid_of(0);
        end
        check("rst_mid_no_stale", seen, 0);
        op_int(0, 100, 200, 1'b0, 1, "after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
